// File: rtl/ahb_slave_arbiter_gen_if.sv
// rtl/ahb_slave_arbiter_gen_if.sv - request/grant bundle between masters and one slave-port arbiter
interface ahb_slave_arbiter_gen_if #(
    parameter int MASTER_NUM = 4,
    parameter int PRIOR_BIT  = 2,
    parameter int IDX_BIT    = 2
);
    logic [MASTER_NUM-1:0]                hreq;
    logic [MASTER_NUM-1:0][PRIOR_BIT-1:0] hprior;
    logic [MASTER_NUM-1:0][1:0]           htrans;
    logic [MASTER_NUM-1:0][2:0]           hburst;
    logic                                 hready;
    logic [MASTER_NUM-1:0]                hgrant;
    logic [IDX_BIT-1:0]                   hmaster;
    logic                                 hsel;
    logic                                 hlast;

    modport master (
        output hreq, hprior, htrans, hburst, hready,
        input  hgrant, hmaster, hsel, hlast
    );

    modport slave (
        input  hreq, hprior, htrans, hburst, hready,
        output hgrant, hmaster, hsel, hlast
    );
endinterface

// File: rtl/ahb_slave_arbiter_gen.sv
// rtl/ahb_slave_arbiter_gen.sv - per-slave AHB arbiter holding the grant for a whole burst
module ahb_slave_arbiter_gen #(
    parameter int MASTER_NUM     = 4,
    parameter int PRIOR_LEVEL    = 4,
    parameter int PRIOR_BIT      = (PRIOR_LEVEL > 1) ? $clog2(PRIOR_LEVEL) : 1,
    parameter int ARB_MODE       = 0,
    parameter int INCR_MAX_BEATS = 16,
    parameter int IDX_BIT        = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1
) (
    input logic                    hclk,
    input logic                    hreset_n,
    ahb_slave_arbiter_gen_if.slave bus
);
    localparam int CNT_W = $clog2((INCR_MAX_BEATS > 16) ? INCR_MAX_BEATS : 16) + 1;

    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_NONSEQ = 2'd2;

    typedef enum logic [1:0] {ST_IDLE, ST_OWNED, ST_BURST} state_t;

    state_t                  state_q;
    logic [MASTER_NUM-1:0]   hgrant_q;
    logic [IDX_BIT-1:0]      hmaster_q;
    logic [IDX_BIT-1:0]      rr_ptr_q;
    logic [CNT_W-1:0]        count_q;
    logic [CNT_W-1:0]        limit_q;
    logic                    incr_q;

    function automatic logic [CNT_W-1:0] burst_limit(input logic [2:0] b);
        case (b)
            3'd0:       return CNT_W'(1);
            3'd1:       return CNT_W'(INCR_MAX_BEATS);
            3'd2, 3'd3: return CNT_W'(4);
            3'd4, 3'd5: return CNT_W'(8);
            default:    return CNT_W'(16);
        endcase
    endfunction

    // Winner selection; only one policy is live per instance.
    logic                   any_req;
    logic                   found;
    logic [IDX_BIT-1:0]     win;
    logic [PRIOR_BIT-1:0]   best_p;
    logic [MASTER_NUM-1:0]  grant_d;
    int                     j;

    always_comb begin
        any_req = |bus.hreq;
        found   = 1'b0;
        win     = '0;
        best_p  = '0;
        j       = 0;
        grant_d = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (ARB_MODE == 2) begin
                j = int'(rr_ptr_q) + i;
                if (j >= MASTER_NUM) j = j - MASTER_NUM;
                if (bus.hreq[j] && !found) begin
                    found = 1'b1;
                    win   = IDX_BIT'(j);
                end
            end else if (ARB_MODE == 1) begin
                if (bus.hreq[i] && (!found || (bus.hprior[i] > best_p))) begin
                    found  = 1'b1;
                    win    = IDX_BIT'(i);
                    best_p = bus.hprior[i];
                end
            end else begin
                if (bus.hreq[i] && !found) begin
                    found = 1'b1;
                    win   = IDX_BIT'(i);
                end
            end
        end
        grant_d[win] = 1'b1;
    end

    logic [1:0]        own_trans;
    logic [2:0]        own_burst;
    logic              own_req;
    logic              beat_ok;
    logic [CNT_W-1:0]  new_limit;
    logic              start;
    logic              last_beat;
    logic              release_early;
    logic              handover;

    always_comb begin
        own_trans     = bus.htrans[hmaster_q];
        own_burst     = bus.hburst[hmaster_q];
        own_req       = bus.hreq[hmaster_q];
        beat_ok       = bus.hready && own_trans[1];
        new_limit     = burst_limit(own_burst);
        start         = 1'b0;
        last_beat     = 1'b0;
        release_early = 1'b0;
        case (state_q)
            ST_OWNED: begin
                if (beat_ok && own_trans == TR_NONSEQ) begin
                    start     = 1'b1;
                    last_beat = (new_limit == CNT_W'(1));
                end else if (!own_req && own_trans == TR_IDLE) begin
                    release_early = 1'b1;
                end
            end
            ST_BURST: begin
                // A fresh NONSEQ mid-burst restarts counting with the new burst type.
                if (beat_ok && own_trans == TR_NONSEQ) begin
                    start     = 1'b1;
                    last_beat = (new_limit == CNT_W'(1));
                end else if (beat_ok) begin
                    last_beat = (count_q == limit_q - CNT_W'(1));
                end else if (incr_q && own_trans == TR_IDLE && !own_req) begin
                    release_early = 1'b1;
                end
            end
            default: ;
        endcase
        handover = last_beat || release_early || (state_q == ST_IDLE);
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q   <= ST_IDLE;
            hgrant_q  <= '0;
            hmaster_q <= '0;
            rr_ptr_q  <= '0;
            count_q   <= '0;
            limit_q   <= '0;
            incr_q    <= 1'b0;
        end else if (handover) begin
            count_q <= '0;
            if (any_req) begin
                state_q   <= ST_OWNED;
                hgrant_q  <= grant_d;
                hmaster_q <= win;
                rr_ptr_q  <= (win == IDX_BIT'(MASTER_NUM - 1)) ? '0 : win + IDX_BIT'(1);
            end else begin
                state_q  <= ST_IDLE;
                hgrant_q <= '0;
            end
        end else if (start) begin
            state_q <= ST_BURST;
            count_q <= CNT_W'(1);
            limit_q <= new_limit;
            incr_q  <= (own_burst == 3'd1);
        end else if (state_q == ST_BURST && beat_ok) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign bus.hgrant  = hgrant_q;
    assign bus.hmaster = hmaster_q;
    assign bus.hsel    = |hgrant_q;
    assign bus.hlast   = last_beat;
endmodule
